// File: rtl/instr_decoder_pipe.sv
// Instruction register plus decoder for the 8-bit microprocessor, with
// stall/flush/valid handling and saturating instruction and watch counters.
module instr_decoder_pipe #(
  parameter int         CNT_W      = 16,
  parameter logic [7:0] WATCH_OP   = 8'hC8,
  parameter logic [7:0] WATCH_MASK = 8'hFF
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic [7:0]       next_instr,
  input  logic             stall,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic [7:0]       ir,
  output logic             valid,
  output logic [3:0]       ir_nibble,
  output logic [3:0]       source_sel,
  output logic [8:0]       reg_en,
  output logic             i_sel,
  output logic             x_sel,
  output logic             y_sel,
  output logic             jmp,
  output logic             jmp_nz,
  output logic             watch_hit,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] watch_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [7:0]       ir_q, ir_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic [CNT_W-1:0] watch_count_q, watch_count_d;

  logic       exec, hit;
  logic       is_li, is_mov, is_alu;
  logic [2:0] dst, src;
  logic [8:0] raw_en;

  assign exec   = valid_q & ~stall & ~sync_reset;
  assign is_li  = ~ir_q[7];
  assign is_mov = (ir_q[7:6] == 2'b10);
  assign is_alu = (ir_q[7:5] == 3'b110);
  assign dst    = is_li ? ir_q[6:4] : ir_q[5:3];
  assign src    = ir_q[2:0];
  assign hit    = exec & ((ir_q & WATCH_MASK) == (WATCH_OP & WATCH_MASK));

  always_comb begin
    raw_en = 9'h000;
    if (is_li || is_mov) begin
      case (dst)
        3'd0: raw_en[0] = 1'b1;
        3'd1: raw_en[1] = 1'b1;
        3'd2: raw_en[2] = 1'b1;
        3'd3: raw_en[3] = 1'b1;
        3'd4: raw_en[8] = 1'b1;
        3'd5: raw_en[5] = 1'b1;
        3'd6: raw_en[6] = 1'b1;
        default: begin
          // A dm write post-increments i
          raw_en[7] = 1'b1;
          raw_en[6] = 1'b1;
        end
      endcase
    end
    if (is_mov && (src == 3'd7)) raw_en[6] = 1'b1;
    if (is_alu) raw_en[4] = 1'b1;
  end

  always_comb begin
    if (sync_reset)                     source_sel = 4'd10;
    else if (is_li)                     source_sel = 4'd8;
    else if (is_mov && (src == 3'd4))   source_sel = 4'd4;
    else if (is_mov && (dst == src))    source_sel = 4'd9;
    else                                source_sel = {1'b0, src};
  end

  always_comb begin
    ir_d    = ir_q;
    valid_d = valid_q;
    if (flush) begin
      ir_d    = next_instr;
      valid_d = 1'b0;
    end else if (!stall) begin
      ir_d    = next_instr;
      valid_d = 1'b1;
    end
  end

  // A clear coinciding with an executing instruction wins; that one is not counted
  always_comb begin
    instr_count_d = instr_count_q;
    watch_count_d = watch_count_q;
    if (cnt_clr) begin
      instr_count_d = '0;
      watch_count_d = '0;
    end else begin
      if (exec && (instr_count_q != CNT_MAX)) instr_count_d = instr_count_q + CNT_ONE;
      if (hit && (watch_count_q != CNT_MAX))  watch_count_d = watch_count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      ir_q          <= 8'h00;
      valid_q       <= 1'b0;
      instr_count_q <= '0;
      watch_count_q <= '0;
    end else begin
      ir_q          <= ir_d;
      valid_q       <= valid_d;
      instr_count_q <= instr_count_d;
      watch_count_q <= watch_count_d;
    end
  end

  assign ir          = ir_q;
  assign valid       = valid_q;
  assign ir_nibble   = ir_q[3:0];
  assign reg_en      = sync_reset ? 9'h1FF : (exec ? raw_en : 9'h000);
  assign i_sel       = ~sync_reset & ~((is_li || is_mov) && (dst == 3'd6));
  assign x_sel       = ~sync_reset & is_alu & ir_q[4];
  assign y_sel       = ~sync_reset & is_alu & ir_q[3];
  assign jmp         = exec & (ir_q[7:4] == 4'hE);
  assign jmp_nz      = exec & (ir_q[7:4] == 4'hF);
  assign watch_hit   = hit;
  assign instr_count = instr_count_q;
  assign watch_count = watch_count_q;

endmodule

// File: tb/tb_instr_decoder_pipe.sv
// Directed bench for instr_decoder_pipe: a 16-bit-counter instance and a
// 3-bit-counter instance share the same stimulus.
module tb_instr_decoder_pipe;

  logic       clk = 1'b0;
  logic       sync_reset, stall, flush, cnt_clr;
  logic [7:0] next_instr;

  logic [7:0]  ir_a, ir_b;
  logic        valid_a, valid_b;
  logic [3:0]  nib_a, nib_b, ss_a, ss_b;
  logic [8:0]  en_a, en_b;
  logic        isel_a, isel_b, xs_a, xs_b, ys_a, ys_b;
  logic        jmp_a, jmp_b, jnz_a, jnz_b, wh_a, wh_b;
  logic [15:0] icnt_a, wcnt_a;
  logic [2:0]  icnt_b, wcnt_b;

  int vec_count  = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instr_decoder_pipe #(.CNT_W(16)) dut_a (
    .clk(clk), .sync_reset(sync_reset), .next_instr(next_instr), .stall(stall),
    .flush(flush), .cnt_clr(cnt_clr), .ir(ir_a), .valid(valid_a), .ir_nibble(nib_a),
    .source_sel(ss_a), .reg_en(en_a), .i_sel(isel_a), .x_sel(xs_a), .y_sel(ys_a),
    .jmp(jmp_a), .jmp_nz(jnz_a), .watch_hit(wh_a), .instr_count(icnt_a),
    .watch_count(wcnt_a)
  );

  instr_decoder_pipe #(.CNT_W(3)) dut_b (
    .clk(clk), .sync_reset(sync_reset), .next_instr(next_instr), .stall(stall),
    .flush(flush), .cnt_clr(cnt_clr), .ir(ir_b), .valid(valid_b), .ir_nibble(nib_b),
    .source_sel(ss_b), .reg_en(en_b), .i_sel(isel_b), .x_sel(xs_b), .y_sel(ys_b),
    .jmp(jmp_b), .jmp_nz(jnz_b), .watch_hit(wh_b), .instr_count(icnt_b),
    .watch_count(wcnt_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive this cycle's inputs, then let the combinational decode settle
  task automatic applyStimulus(input logic rst, input logic [7:0] instr,
                               input logic stl, input logic fls, input logic clr);
    sync_reset = rst;
    next_instr = instr;
    stall      = stl;
    flush      = fls;
    cnt_clr    = clr;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Reset held two cycles
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_reg_en", en_a, 9'h1FF);
    checkOutput("rst_src", ss_a, 4'd10);
    checkOutput("rst_jmp", jmp_a, 1'b0);
    checkOutput("rst_isel", isel_a, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("rst_valid", valid_a, 1'b0);
    checkOutput("rst_icnt", icnt_a, 16'd0);
    checkOutput("rst_wcnt", wcnt_a, 16'd0);

    // Release: first live instruction is loaded on the first edge without reset
    applyStimulus(1'b0, 8'h35, 1'b0, 1'b0, 1'b0);
    checkOutput("bubble_reg_en", en_a, 9'h000);
    tick();

    applyStimulus(1'b0, 8'hBF, 1'b0, 1'b0, 1'b0);
    checkOutput("li35_valid", valid_a, 1'b1);
    checkOutput("li35_reg_en", en_a, 9'h008);
    checkOutput("li35_src", ss_a, 4'd8);
    checkOutput("li35_nib", nib_a, 4'd5);
    tick();
    checkOutput("li35_icnt", icnt_a, 16'd1);

    applyStimulus(1'b0, 8'h8C, 1'b0, 1'b0, 1'b0);
    checkOutput("movBF_reg_en", en_a, 9'h0C0);
    checkOutput("movBF_src", ss_a, 4'd9);
    tick();

    // 8C = 10_001_100: destination x1, source r
    applyStimulus(1'b0, 8'h87, 1'b0, 1'b0, 1'b0);
    checkOutput("mov8C_src", ss_a, 4'd4);
    checkOutput("mov8C_reg_en", en_a, 9'h002);
    tick();

    applyStimulus(1'b0, 8'hB0, 1'b0, 1'b0, 1'b0);
    checkOutput("mov87_reg_en", en_a, 9'h041);
    checkOutput("mov87_src", ss_a, 4'd7);
    tick();

    applyStimulus(1'b0, 8'hD8, 1'b0, 1'b0, 1'b0);
    checkOutput("movB0_reg_en", en_a, 9'h040);
    checkOutput("movB0_isel", isel_a, 1'b0);
    tick();

    applyStimulus(1'b0, 8'hE3, 1'b0, 1'b0, 1'b0);
    checkOutput("aluD8_reg_en", en_a, 9'h010);
    checkOutput("aluD8_xsel", xs_a, 1'b1);
    checkOutput("aluD8_ysel", ys_a, 1'b1);
    checkOutput("aluD8_isel", isel_a, 1'b1);
    tick();

    applyStimulus(1'b0, 8'hF3, 1'b0, 1'b0, 1'b0);
    checkOutput("jmpE3_jmp", jmp_a, 1'b1);
    checkOutput("jmpE3_jnz", jnz_a, 1'b0);
    checkOutput("jmpE3_src", ss_a, 4'd3);
    checkOutput("jmpE3_reg_en", en_a, 9'h000);
    tick();

    applyStimulus(1'b0, 8'hC8, 1'b0, 1'b0, 1'b0);
    checkOutput("jnzF3_jnz", jnz_a, 1'b1);
    checkOutput("jnzF3_jmp", jmp_a, 1'b0);
    tick();
    checkOutput("pre_stall_icnt", icnt_a, 16'd8);
    checkOutput("pre_stall_icnt3", icnt_b, 3'd7);

    // C8 held by a three-cycle stall
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput("stall_reg_en", en_a, 9'h000);
      checkOutput("stall_watch", wh_a, 1'b0);
      checkOutput("stall_ir", ir_a, 8'hC8);
      tick();
    end
    checkOutput("stall_icnt", icnt_a, 16'd8);
    checkOutput("stall_wcnt", wcnt_a, 16'd0);

    // Released cycle executes C8 while the next load (40) is flushed
    applyStimulus(1'b0, 8'h40, 1'b0, 1'b1, 1'b0);
    checkOutput("release_watch", wh_a, 1'b1);
    checkOutput("release_reg_en", en_a, 9'h010);
    tick();
    checkOutput("release_icnt", icnt_a, 16'd9);
    checkOutput("release_wcnt", wcnt_a, 16'd1);

    applyStimulus(1'b0, 8'h12, 1'b1, 1'b1, 1'b0);
    checkOutput("flush_valid", valid_a, 1'b0);
    checkOutput("flush_reg_en", en_a, 9'h000);
    checkOutput("flush_src", ss_a, 4'd8);
    checkOutput("flush_watch", wh_a, 1'b0);
    tick();
    checkOutput("flush_stall_ir", ir_a, 8'h12);
    checkOutput("flush_stall_valid", valid_a, 1'b0);
    checkOutput("flush_icnt", icnt_a, 16'd9);

    applyStimulus(1'b0, 8'h40, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'hC8, 1'b0, 1'b0, 1'b0);
    checkOutput("li40_reg_en", en_a, 9'h100);
    tick();
    checkOutput("li40_icnt", icnt_a, 16'd10);

    // Clear while C8 executes: cleared, not counted
    applyStimulus(1'b0, 8'hC8, 1'b0, 1'b0, 1'b1);
    checkOutput("clr_exec_watch", wh_a, 1'b1);
    tick();
    checkOutput("clr_icnt", icnt_a, 16'd0);
    checkOutput("clr_wcnt", wcnt_a, 16'd0);
    checkOutput("clr_icnt3", icnt_b, 3'd0);

    // Ten executed C8 instructions; the 3-bit counters stick at 7
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b0, 8'hC8, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("sat_icnt3", icnt_b, (k > 7) ? 3'd7 : 3'(k));
      checkOutput("sat_wcnt3", wcnt_b, (k > 7) ? 3'd7 : 3'(k));
    end
    checkOutput("sat_icnt16", icnt_a, 16'd10);
    checkOutput("sat_wcnt16", wcnt_a, 16'd10);

    applyStimulus(1'b0, 8'hC8, 1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("sat_clr_icnt3", icnt_b, 3'd0);
    checkOutput("sat_clr_wcnt3", wcnt_b, 3'd0);

    // Reset mid-stream discards the in-flight instruction
    applyStimulus(1'b1, 8'h35, 1'b0, 1'b0, 1'b0);
    checkOutput("mid_rst_reg_en", en_a, 9'h1FF);
    checkOutput("mid_rst_src", ss_a, 4'd10);
    checkOutput("mid_rst_xsel", xs_a, 1'b0);
    checkOutput("mid_rst_watch", wh_a, 1'b0);
    tick();
    applyStimulus(1'b0, 8'hE0, 1'b0, 1'b0, 1'b0);
    checkOutput("mid_rst_ir", ir_a, 8'h00);
    checkOutput("mid_rst_valid", valid_a, 1'b0);
    checkOutput("mid_rst_jmp", jmp_a, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_jmp", jmp_a, 1'b1);
    checkOutput("post_rst_nib", nib_a, 4'd0);
    tick();
    checkOutput("post_rst_icnt", icnt_a, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
